bram_arbiter: RTL and testbench

// - Two-port front end for the single-ported bram: merges the core's instruction-fetch and data ports onto one

---
 rtl/bram_arbiter_pkg.sv | 27 ++
 rtl/bram_arb_slot.sv | 52 +++++
 rtl/bram_arbiter.sv | 157 +++++++++++++++
 tb/tb_bram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bram_arbiter_pkg
//   Shared types and constants for the bram front end.
//   - bram_depth : number of 32-bit words in the bram behind the arbiter
//   - bram_cycle : extra wait cycles the bram inserts before bram_ready
//   - arb_state_t: arbiter FSM state (idle, serving instruction, serving data)
//   - bram_req_t : one captured request (byte address, store data, strobes)
// -----------------------------------------------------------------------------
package bram_arbiter_pkg;

    localparam int unsigned bram_depth = 1024;
    localparam int unsigned bram_cycle = 0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    // wstrb == 4'b0000 marks a load; instruction requests always carry zeros.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bram_req_t;

endpackage

// File: rtl/bram_arb_slot.sv
// -----------------------------------------------------------------------------
// bram_arb_slot
//   One-entry request capture register with a full flag. A request stays in
//   the slot from its valid strobe until the arbiter has completed it.
//   Ports:
//     clock  in   single clock
//     reset  in   synchronous, active-low; empties the slot
//     load   in   requester strobe; captures req when the slot is free
//                 (or is being freed on this same edge)
//     clear  in   arbiter completed the held request on this edge
//     req    in   incoming request payload
//     full   out  slot holds a pending or in-service request
//     held   out  captured payload, meaningful only while full=1
// -----------------------------------------------------------------------------
module bram_arb_slot
    import bram_arbiter_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      load,
    input  logic      clear,
    input  bram_req_t req,
    output logic      full,
    output bram_req_t held
);

    // A strobe into an occupied slot is a requester protocol error; it is
    // dropped so the request already in service keeps a stable payload.
    logic accept;
    assign accept = load && (clear || !full);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= load;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    // NOTE: the payload register is deliberately left out of reset; the full
    // flag alone qualifies it, which keeps the reset net off 68 data flops.
    always_ff @(posedge clock) begin
        if (accept) begin
            held <= req;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//   Merges the instruction-fetch and data ports of the core onto the single
//   request channel of the bram. Each port owns a one-entry capture slot; the
//   FSM grants one request at a time, data first, with an anti-starvation
//   limit so a waiting fetch gets through after starve_limit data grants.
//   On bram_ready the granted port sees ready/rdata combinationally and the
//   next grant is decided on the same edge, so back-to-back requests have no
//   idle cycle on the bram side.
//   Parameters:
//     starve_limit  data grants allowed while a fetch waits (1..15)
//   Ports:
//     clock, reset                 single clock, synchronous active-low reset
//     imem_valid/addr              fetch request strobe and byte address
//     imem_rdata/ready             fetch completion (one-cycle pulse)
//     dmem_valid/addr/wdata/wstrb  data request; wstrb == 0 means load
//     dmem_rdata/ready             data completion (one-cycle pulse)
//     bram_valid/instr/addr/wdata/wstrb  registered request to the bram,
//                                  held stable until bram_ready
//     bram_rdata/ready             bram response
// -----------------------------------------------------------------------------
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned starve_limit = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    localparam logic [3:0] limit = 4'(starve_limit);

    arb_state_t state;
    logic [3:0] starve_cnt;

    bram_req_t  i_in, d_in;
    bram_req_t  i_held, d_held;
    bram_req_t  i_req, d_req, sel_req;
    logic       i_full, d_full;
    logic       free_i, free_d;
    logic       i_keep, d_keep;
    logic       i_cand, d_cand;
    logic       decide, pick_i, pick_d;

    assign i_in = '{addr: imem_addr, wdata: 32'h0, wstrb: 4'h0};
    assign d_in = '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

    // The granted slot is freed on the completing edge.
    assign free_i = (state == BUSY_I) && bram_ready;
    assign free_d = (state == BUSY_D) && bram_ready;

    bram_arb_slot u_slot_i (
        .clock (clock),
        .reset (reset),
        .load  (imem_valid),
        .clear (free_i),
        .req   (i_in),
        .full  (i_full),
        .held  (i_held)
    );

    bram_arb_slot u_slot_d (
        .clock (clock),
        .reset (reset),
        .load  (dmem_valid),
        .clear (free_d),
        .req   (d_in),
        .full  (d_full),
        .held  (d_held)
    );

    // A slot that is completing this edge no longer competes; a strobe
    // arriving on the same edge competes directly from the port inputs so
    // it can be granted without first passing through the slot.
    assign i_keep = i_full && !free_i;
    assign d_keep = d_full && !free_d;
    assign i_cand = i_keep || imem_valid;
    assign d_cand = d_keep || dmem_valid;
    assign i_req  = i_keep ? i_held : i_in;
    assign d_req  = d_keep ? d_held : d_in;

    assign decide  = (state == IDLE) || free_i || free_d;
    assign pick_i  = i_cand && (!d_cand || (starve_cnt >= limit));
    assign pick_d  = d_cand && !pick_i;
    assign sel_req = pick_d ? d_req : i_req;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            bram_valid <= 1'b0;
            bram_instr <= 1'b0;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            bram_wstrb <= 4'h0;
        end else if (decide) begin
            if (pick_d || pick_i) begin
                state      <= pick_d ? BUSY_D : BUSY_I;
                bram_valid <= 1'b1;
                bram_instr <= pick_i;
                bram_addr  <= sel_req.addr;
                bram_wdata <= sel_req.wdata;
                bram_wstrb <= sel_req.wstrb;
                if (pick_i) begin
                    starve_cnt <= 4'd0;
                end else if (i_cand) begin
                    // Bounded by limit: at limit the fetch wins instead.
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                state      <= IDLE;
                bram_valid <= 1'b0;
                bram_instr <= 1'b0;
            end
        end
    end

    // Only the port being served sees the response; bram_ready while IDLE
    // matches neither free_* term and is ignored.
    // NOTE: every output of this always_comb gets a default first, so no
    // path through it leaves a value unassigned and no latch is inferred.
    always_comb begin
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        if (free_i) begin
            imem_ready = 1'b1;
            imem_rdata = bram_rdata;
        end
        if (free_d) begin
            dmem_ready = 1'b1;
            dmem_rdata = bram_rdata;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//   Directed bench for bram_arbiter with a behavioural bram: registered read,
//   bram_lat extra wait cycles, byte-strobed writes. Word i of the bram is
//   preloaded with 32'hC0DE_0000 | i so expected read data is easy to derive.
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata;
    logic        bram_ready;

    int n_vec = 0;
    int n_err = 0;
    int bram_lat = bram_cycle;

    always #5 clock = ~clock;

    bram_arbiter #(.starve_limit(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Behavioural bram: samples the request on the rising edge, answers 1ns
    // later. Ready comes one cycle after valid is first seen plus bram_lat.
    initial begin : bram_model
        logic [31:0] mem [bram_depth];
        logic        v, r;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        int          idx;
        int          wait_cnt;
        for (int i = 0; i < int'(bram_depth); i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        bram_ready = 1'b0;
        bram_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
        forever begin
            @(posedge clock);
            v = bram_valid; r = bram_ready; a = bram_addr; wd = bram_wdata; ws = bram_wstrb;
            #1;
            if (v && !r && wait_cnt >= bram_lat) begin
                idx = int'((a >> 2) % 32'(bram_depth));
                bram_rdata = mem[idx];
                for (int b = 0; b < 4; b++) if (ws[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
                bram_ready = 1'b1;
                wait_cnt   = 0;
            end else if (v && !r) begin
                wait_cnt++;
                bram_ready = 1'b0;
                bram_rdata = 32'hDEAD_BEEF;
            end else begin
                wait_cnt   = 0;
                bram_ready = 1'b0;
                bram_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Continuous protocol checks: exclusive one-cycle readies, zero rdata on
    // the idle port, and a frozen payload while the bram is still working.
    initial begin : monitor
        logic        prev_hold, prev_i, prev_d, prev_instr;
        logic [31:0] prev_addr, prev_wdata;
        logic [3:0]  prev_wstrb;
        prev_hold = 1'b0; prev_i = 1'b0; prev_d = 1'b0;
        prev_instr = 1'b0; prev_addr = '0; prev_wdata = '0; prev_wstrb = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                check("ready_overlap", 32'(imem_ready & dmem_ready), 32'h0);
                if (!imem_ready) check("imem_rdata_idle", imem_rdata, 32'h0);
                if (!dmem_ready) check("dmem_rdata_idle", dmem_rdata, 32'h0);
                if (prev_i) check("imem_ready_width", 32'(imem_ready), 32'h0);
                if (prev_d) check("dmem_ready_width", 32'(dmem_ready), 32'h0);
                if (prev_hold && bram_valid) begin
                    check("hold_instr", 32'(bram_instr), 32'(prev_instr));
                    check("hold_addr", bram_addr, prev_addr);
                    check("hold_wdata", bram_wdata, prev_wdata);
                    check("hold_wstrb", 32'(bram_wstrb), 32'(prev_wstrb));
                end
            end
            prev_hold  = (reset === 1'b1) && bram_valid && !bram_ready;
            prev_i     = imem_ready;
            prev_d     = dmem_ready;
            prev_instr = bram_instr;
            prev_addr  = bram_addr;
            prev_wdata = bram_wdata;
            prev_wstrb = bram_wstrb;
        end
    end

    // Drives one cycle of request strobes starting at the current falling
    // edge; returns on the next falling edge with the strobes dropped.
    task automatic issue(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic [31:0] da,
                         input logic [31:0] dw, input logic [3:0] ds);
        imem_valid = iv; imem_addr  = ia;
        dmem_valid = dv; dmem_addr  = da;
        dmem_wdata = dw; dmem_wstrb = ds;
        @(negedge clock);
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    // Waits (bounded) for a ready pulse; waited = falling edges advanced.
    task automatic wait_ready(input string tag, input logic data_port, output int waited);
        waited = 0;
        while (!(data_port ? dmem_ready : imem_ready) && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check(tag, 32'(data_port ? dmem_ready : imem_ready), 32'h1);
    endtask

    initial begin : stimulus
        int  w;
        int  d_done;
        logic got_i;

        reset = 1'b0;
        imem_valid = 1'b0; imem_addr = '0;
        dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_bram_valid", 32'(bram_valid), 32'h0);
        check("rst_bram_instr", 32'(bram_instr), 32'h0);
        check("rst_bram_addr", bram_addr, 32'h0);
        check("rst_bram_wdata", bram_wdata, 32'h0);
        check("rst_bram_wstrb", 32'(bram_wstrb), 32'h0);
        check("rst_readies", 32'({imem_ready, dmem_ready}), 32'h0);
        check("rst_imem_rdata", imem_rdata, 32'h0);
        check("rst_dmem_rdata", dmem_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // Single fetch, no bram wait: ready two cycles after the strobe
        bram_lat = 0;
        issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        check("f_bram_valid", 32'(bram_valid), 32'h1);
        check("f_bram_instr", 32'(bram_instr), 32'h1);
        check("f_bram_addr", bram_addr, 32'h10);
        check("f_bram_wstrb", 32'(bram_wstrb), 32'h0);
        @(negedge clock);
        check("f_imem_ready", 32'(imem_ready), 32'h1);
        check("f_imem_rdata", imem_rdata, 32'hC0DE_0004);
        check("f_dmem_ready", 32'(dmem_ready), 32'h0);
        @(negedge clock);
        check("f_bram_idle", 32'(bram_valid), 32'h0);

        // Store then load, two bram wait cycles
        bram_lat = 2;
        issue(1'b0, 32'h0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0011);
        check("st_bram_instr", 32'(bram_instr), 32'h0);
        check("st_bram_addr", bram_addr, 32'h20);
        check("st_bram_wdata", bram_wdata, 32'hAABB_CCDD);
        check("st_bram_wstrb", 32'(bram_wstrb), 32'h3);
        wait_ready("st_ready", 1'b1, w);
        check("st_latency", 32'(w), 32'd3);
        check("st_imem_ready", 32'(imem_ready), 32'h0);
        @(negedge clock);
        issue(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'b0000);
        check("ld_bram_wstrb", 32'(bram_wstrb), 32'h0);
        wait_ready("ld_ready", 1'b1, w);
        check("ld_latency", 32'(w), 32'd3);
        check("ld_dmem_rdata", dmem_rdata, 32'hC0DE_CCDD);
        check("ld_imem_ready", 32'(imem_ready), 32'h0);
        @(negedge clock);

        // Simultaneous strobes: data first, fetch follows with no bubble
        bram_lat = 0;
        issue(1'b1, 32'h0, 1'b1, 32'h40, 32'h0, 4'h0);
        check("sim_first_instr", 32'(bram_instr), 32'h0);
        check("sim_first_addr", bram_addr, 32'h40);
        @(negedge clock);
        check("sim_dmem_ready", 32'(dmem_ready), 32'h1);
        check("sim_dmem_rdata", dmem_rdata, 32'hC0DE_0010);
        @(negedge clock);
        check("sim_b2b_valid", 32'(bram_valid), 32'h1);
        check("sim_b2b_instr", 32'(bram_instr), 32'h1);
        check("sim_b2b_addr", bram_addr, 32'h0);
        @(negedge clock);
        check("sim_imem_ready", 32'(imem_ready), 32'h1);
        check("sim_imem_rdata", imem_rdata, 32'hC0DE_0000);
        @(negedge clock);
        check("sim_idle", 32'(bram_valid), 32'h0);

        // Starvation: data re-requests on every completion; the fetch must
        // be granted right after the fourth data grant.
        issue(1'b1, 32'h4, 1'b1, 32'h100, 32'h0, 4'h0);
        d_done = 0;
        got_i  = 1'b0;
        for (int k = 0; k < 100 && !got_i; k++) begin
            dmem_valid = 1'b0;
            if (imem_ready) begin
                got_i = 1'b1;
                check("stv_imem_rdata", imem_rdata, 32'hC0DE_0001);
            end else begin
                if (dmem_ready) begin
                    d_done++;
                    dmem_valid = 1'b1;
                    dmem_addr  = 32'h100 + 32'(4 * d_done);
                    dmem_wstrb = 4'h0;
                end
                @(negedge clock);
            end
        end
        dmem_valid = 1'b0;
        check("stv_imem_seen", 32'(got_i), 32'h1);
        check("stv_data_grants", 32'(d_done), 32'd4);
        wait_ready("stv_tail_ready", 1'b1, w);
        check("stv_tail_rdata", dmem_rdata, 32'hC0DE_0044);
        @(negedge clock);

        // Reset while serving a load with three bram wait cycles. The bram
        // answers on the cycle after reset; the idle arbiter must ignore it.
        bram_lat = 3;
        issue(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 4'h0);
        check("rm_busy", 32'(bram_valid), 32'h1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rm_bram_valid", 32'(bram_valid), 32'h0);
        check("rm_bram_addr", bram_addr, 32'h0);
        check("rm_dmem_ready", 32'(dmem_ready), 32'h0);
        check("rm_dmem_rdata", dmem_rdata, 32'h0);
        check("rm_imem_ready", 32'(imem_ready), 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rm_stays_idle", 32'(bram_valid), 32'h0);

        // Fetch after reset must not be pre-empted by a stale data slot
        bram_lat = 0;
        issue(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0);
        check("pr_bram_instr", 32'(bram_instr), 32'h1);
        check("pr_bram_addr", bram_addr, 32'h8);
        @(negedge clock);
        check("pr_imem_ready", 32'(imem_ready), 32'h1);
        check("pr_imem_rdata", imem_rdata, 32'hC0DE_0002);
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
